// File: rtl/bcd_display_decoder.sv
// bcd_display_decoder: captures BCD digits from the keypad encoder into a
// shift-left MM:SS entry register and drives a time-multiplexed, 4-digit,
// active-high 7-segment display with active-low one-hot anodes.
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, leading
// zero digits (M10, M1, S10) are blanked. S1 is never blanked.

// Per-digit segment decoder with an optional blank override.
module bcd_seg_lane (
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);
   // gfedcba pattern. Non-BCD codes show a dash.
   always_comb begin
      seg = 7'b1000000;
      if (!blank) begin
         case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b1000000;
         endcase
      end else begin
         seg = 7'b0000000;
      end
   end
endmodule

module bcd_display_decoder #(
   parameter int SCAN_DIV = 1000,
   parameter int CNT_W    = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  bcd,
   input  logic        loadn,
   input  logic        enablen,
   output logic [15:0] digits,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);
   localparam int NUM_DIG = 4;

   typedef struct packed {
      logic       vld;
      logic [3:0] code;
   } load_req_t;

   logic             l1, l2, armed;
   logic [3:0]       bcd_q;
   load_req_t        req;
   logic [CNT_W-1:0] div_cnt;
   logic [1:0]       scan_idx;
   logic [NUM_DIG-1:0]            blank;
   logic [NUM_DIG-1:0][3:0]       dig_v;
   logic [NUM_DIG-1:0][6:0]       lane_seg;

   // Load pipeline: two-stage loadn history plus aligned BCD capture.
   // armed stays low after reset until loadn has been seen high, so a key
   // still held across reset release cannot produce a load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l1    <= 1'b1;
         l2    <= 1'b1;
         armed <= 1'b0;
         bcd_q <= 4'd0;
      end else begin
         l1    <= loadn;
         l2    <= l1;
         armed <= armed | loadn;
         bcd_q <= bcd;
      end
   end

   // Accept a load on the falling edge of loadn, enabled, valid BCD only.
   always_comb begin
      req      = '0;
      req.code = bcd_q;
      req.vld  = l2 & ~l1 & armed & ~enablen & (bcd_q <= 4'd9);
   end

   // Entry register: shift left one digit, newest into S1, M10 drops out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          digits <= 16'h0000;
      else if (req.vld) digits <= {digits[11:0], req.code};
   end

   // Scan prescaler and digit index; free-running regardless of enablen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt  <= '0;
         scan_idx <= 2'd0;
      end else if (div_cnt == CNT_W'(SCAN_DIV - 1)) begin
         div_cnt  <= '0;
         scan_idx <= scan_idx + 2'd1;
      end else begin
         div_cnt  <= div_cnt + CNT_W'(1);
      end
   end

   assign dig_v = digits;

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is blank when it and everything to its left are zero; S1 always shows.
   always_comb begin
      blank    = '0;
      blank[3] = (dig_v[3] == 4'd0);
      blank[2] = blank[3] & (dig_v[2] == 4'd0);
      blank[1] = blank[2] & (dig_v[1] == 4'd0);
   end
`else
   // All four digits always shown.
   always_comb begin
      blank = '0;
   end
`endif

   genvar g;
   generate
      for (g = 0; g < NUM_DIG; g++) begin : g_lane
         bcd_seg_lane u_lane (
            .digit (dig_v[g]),
            .blank (blank[g]),
            .seg   (lane_seg[g])
         );
      end
   endgenerate

   // Registered display outputs; everything dark while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= 7'd0;
         dp  <= 1'b0;
      end else if (enablen) begin
         an  <= 4'b1111;
         seg <= 7'd0;
         dp  <= 1'b0;
      end else begin
         an  <= ~(4'b0001 << scan_idx);
         seg <= lane_seg[scan_idx];
         dp  <= (scan_idx == 2'd2);
      end
   end
endmodule

// File: tb/tb_bcd_display_decoder.sv
// Self-checking bench for bcd_display_decoder (SCAN_DIV=4).
// Honors LEADING_ZERO_BLANK_EN when defined for the whole build.
module tb_bcd_display_decoder;
   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  bcd;
   logic        loadn;
   logic        enablen;
   logic [15:0] digits;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_digits;

   logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                                7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

   bcd_display_decoder #(.SCAN_DIV(SCAN_DIV), .CNT_W(10)) dut (
      .clk(clk), .rst(rst), .bcd(bcd), .loadn(loadn), .enablen(enablen),
      .digits(digits), .seg(seg), .dp(dp), .an(an)
   );

   always #5 clk = ~clk;

   // Expected segments for display position idx (0=S1 .. 3=M10).
   function automatic logic [6:0] exp_seg(input int idx);
      int d;
      logic blanked;
      d = (int'(exp_digits) >> (4 * idx)) % 16;
      blanked = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0 && (int'(exp_digits) >> (4 * idx)) == 0) blanked = 1'b1;
`endif
      return blanked ? 7'd0 : seg_tab[d];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d, input int lo, input int hi);
      bcd   = d;
      loadn = 1'b0;
      repeat (lo) step();
      loadn = 1'b1;
      repeat (hi) step();
   endtask

   // Model update for a press that the design should accept.
   task automatic model_load(input logic [3:0] d, input logic en_n);
      if (!en_n && d <= 4'd9) exp_digits = 16'((int'(exp_digits) * 16 + int'(d)) % 65536);
   endtask

   task automatic test_reset();
      rst = 1'b1; loadn = 1'b1; enablen = 1'b0; bcd = 4'd0;
      exp_digits = 16'h0000;
      #1;
      n_checks++;
      if (digits !== 16'h0000 || an !== 4'b1111 || seg !== 7'd0 || dp !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state digits=%h an=%b seg=%b dp=%b required 0000/1111/0/0", digits, an, seg, dp);
      end
      #20 rst = 1'b0;
      #1;
      n_checks++;
      if (an !== 4'b1111) begin
         n_fail++;
         $display("FAIL reset_release_an got %b required 1111", an);
      end
      repeat (4) step();
      n_checks++;
      if (digits !== exp_digits) begin
         n_fail++;
         $display("FAIL reset_no_load digits=%h required %h", digits, exp_digits);
      end
   endtask

   // Watch 16 cycles: one-hot anodes in order, 4 cycles each, right seg/dp.
   task automatic test_scan(input string tag);
      int cnt [4];
      int prev;
      int idx;
      prev = -1;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int c = 0; c < 16; c++) begin
         step();
         case (an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
         endcase
         n_checks++;
         if (idx < 0) begin
            n_fail++;
            $display("FAIL %s an_onehot got %b", tag, an);
         end else begin
            cnt[idx]++;
            n_checks++;
            if (seg !== exp_seg(idx) || dp !== (idx == 2)) begin
               n_fail++;
               $display("FAIL %s seg_dp pos=%0d seg=%b dp=%b required %b/%0d", tag, idx, seg, dp, exp_seg(idx), (idx == 2));
            end
            if (prev >= 0 && idx != prev) begin
               n_checks++;
               if (idx != (prev + 1) % 4) begin
                  n_fail++;
                  $display("FAIL %s scan_order %0d->%0d", tag, prev, idx);
               end
            end
            prev = idx;
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (cnt[i] != SCAN_DIV) begin
            n_fail++;
            $display("FAIL %s dwell pos=%0d got %0d cycles required %0d", tag, i, cnt[i], SCAN_DIV);
         end
      end
   endtask

   task automatic test_key_entry();
      for (int k = 1; k <= 4; k++) begin
         press(4'(k), 3, 3);
         model_load(4'(k), 1'b0);
      end
      n_checks++;
      if (digits !== exp_digits) begin
         n_fail++;
         $display("FAIL key_entry digits=%h required %h", digits, exp_digits);
      end
      test_scan("scan_1234");
   endtask

   task automatic test_hold();
      press(4'd9, 20, 3);
      model_load(4'd9, 1'b0);
      n_checks++;
      if (digits !== exp_digits) begin
         n_fail++;
         $display("FAIL hold_one_shift digits=%h required %h", digits, exp_digits);
      end
   endtask

   task automatic test_invalid();
      for (int k = 0; k < 3; k++) begin
         press(4'($urandom_range(15, 10)), 3, 3);
         n_checks++;
         if (digits !== exp_digits) begin
            n_fail++;
            $display("FAIL invalid_code digits=%h required %h", digits, exp_digits);
         end
      end
   endtask

   task automatic test_enable();
      enablen = 1'b1;
      step();
      n_checks++;
      if (an !== 4'b1111 || seg !== 7'd0 || dp !== 1'b0) begin
         n_fail++;
         $display("FAIL blanked_out an=%b seg=%b dp=%b required 1111/0/0", an, seg, dp);
      end
      press(4'd7, 3, 3);
      n_checks++;
      if (digits !== exp_digits || an !== 4'b1111 || seg !== 7'd0) begin
         n_fail++;
         $display("FAIL enable_drop digits=%h an=%b seg=%b required %h/1111/0", digits, an, seg, exp_digits);
      end
      enablen = 1'b0;
      step();
      test_scan("scan_reenable");
   endtask

   task automatic test_random();
      logic [3:0] d;
      logic en_n;
      for (int k = 0; k < 12; k++) begin
         d    = 4'($urandom_range(15, 0));
         en_n = ($urandom_range(3, 0) == 0);
         enablen = en_n;
         press(d, $urandom_range(4, 1), $urandom_range(4, 1));
         enablen = 1'b0;
         model_load(d, en_n);
         n_checks++;
         if (digits !== exp_digits) begin
            n_fail++;
            $display("FAIL random_press k=%0d d=%0d en_n=%0b digits=%h required %h", k, d, en_n, digits, exp_digits);
         end
      end
      step();
      test_scan("scan_random");
   endtask

   task automatic test_async_reset();
      bcd = 4'd6; loadn = 1'b0;
      step(); step();
      #2 rst = 1'b1;
      #1;
      exp_digits = 16'h0000;
      n_checks++;
      if (digits !== 16'h0000 || an !== 4'b1111) begin
         n_fail++;
         $display("FAIL async_reset digits=%h an=%b required 0000/1111", digits, an);
      end
      #1 rst = 1'b0;
      repeat (5) step();
      n_checks++;
      if (digits !== exp_digits) begin
         n_fail++;
         $display("FAIL held_key_after_reset digits=%h required %h", digits, exp_digits);
      end
      loadn = 1'b1;
      step(); step();
      press(4'd3, 3, 3);
      model_load(4'd3, 1'b0);
      n_checks++;
      if (digits !== exp_digits) begin
         n_fail++;
         $display("FAIL load_after_reset digits=%h required %h", digits, exp_digits);
      end
   endtask

   task automatic test_blank();
      press(4'd0, 2, 2); model_load(4'd0, 1'b0);
      press(4'd0, 2, 2); model_load(4'd0, 1'b0);
      press(4'd5, 2, 2); model_load(4'd5, 1'b0);
      n_checks++;
      if (digits !== exp_digits) begin
         n_fail++;
         $display("FAIL blank_entry digits=%h required %h", digits, exp_digits);
      end
      test_scan("scan_0005");
   endtask

   initial begin
      test_reset();
      test_key_entry();
      test_hold();
      test_invalid();
      test_enable();
      test_random();
      test_async_reset();
      test_blank();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
